mem_store_buffer: RTL
=====================

// Module: mem_store_buffer
// PURPOSE
//   Write-side counterpart of the data-memory read register: accepts store requests from
//   the MEM stage, aligns data and generates byte enables for SB/SH/SW, buffers up to DEPTH
//   stores, and drains them to data memory over a req/ack write port. Sits between the
//   pipeline MEM stage and data memory; the load path uses 'empty' to hold loads until drained.
// PARAMETERS
//   DEPTH   4   number of buffered stores; power of two, >= 2
//   AW      32  address width
//   DW      32  data width; fixed at 32 (4 byte lanes)
// PORTS
//   clk        in   1          system clock; all state updates on rising edge
//   rst_n      in   1          asynchronous, active-low reset
//   st_valid   in   1          store request present
//   st_ready   out  1          buffer can accept a store (= !full)
//   st_addr    in   AW         byte address of store
//   st_data    in   32         store data, right-justified
//   st_size    in   2          00 byte, 01 half, 10 word, 11 illegal
//   mem_req    out  1          head entry valid toward memory
//   mem_ack    in   1          memory accepted head entry this cycle
//   mem_addr   out  AW         word-aligned address {st_addr[AW-1:2],2'b00} of head
//   mem_wdata  out  32         lane-aligned data of head
//   mem_be     out  4          byte enables of head, bit i = byte lane i (little-endian)
//   misalign   out  1          one-cycle pulse: last offered store rejected
//   count      out  log2(DEPTH)+1  entries held
//   empty      out  1          count == 0
// BEHAVIOUR
//   Reset (async assert, sync release): rd/wr pointers 0, count 0, empty 1, st_ready 1,
//     mem_req 0, mem_addr/mem_wdata/mem_be 0, misalign 0; buffered entries discarded.
//   Accept: st_valid & st_ready at rising edge. Legal stores are enqueued; illegal ones are
//     dropped (not enqueued) and misalign = 1 for exactly the following cycle.
//   Illegal: size 11; half with addr[0]=1; word with addr[1:0]!=00. Byte always legal.
//   Alignment (o = addr[1:0]):
//     byte: wdata = {4{d[7:0]}},  be = 4'b0001 << o
//     half: wdata = {2{d[15:0]}}, be = o[1] ? 4'b1100 : 4'b0011
//     word: wdata = d,            be = 4'b1111
//   Memory side: mem_req = !empty; mem_addr/wdata/be present the head entry and stay
//     stable while mem_req=1 and mem_ack=0. mem_ack=1 with mem_req=1 pops head at that
//     edge; mem_ack with mem_req=0 ignored. No combinational path st_* -> mem_*.
//   Latency: store accepted at edge N is visible on mem_req after edge N when buffer was
//     empty; otherwise in FIFO order behind older entries. Order strictly preserved.
//   Full: st_ready=0 when count==DEPTH; push and pop in same cycle impossible when full
//     (no bypass); when not full and not empty, simultaneous push+pop keeps count.
//   Pointers wrap modulo DEPTH; count distinguishes full vs empty.
//   Simultaneous illegal offer + pop: pop proceeds, count decrements, misalign pulses.
//   Reset mid-drain: mem_req drops immediately on rst_n low; pending stores lost.
// TESTING
//   1. Reset -> st_ready=1, empty=1, mem_req=0, count=0, misalign=0.
//   2. SB addr 0x1003 data 0xAB, mem_ack=1 -> next cycle mem_req=1, mem_addr=0x1000,
//      mem_be=4'b1000, mem_wdata=0xABABABAB; popped, empty=1 after ack edge.
//   3. SH addr 0x2002 data 0x1234 -> be=4'b1100, wdata=0x12341234; SH addr 0x2001 ->
//      not enqueued, misalign=1 one cycle, count unchanged.
//   4. mem_ack=0, push DEPTH words 0x10,0x14,0x18,0x1C -> count=4, st_ready=0, 5th offer
//      not accepted; head held at 0x10 stable across stall cycles.
//   5. Release mem_ack=1 -> addresses drained in order 0x10,0x14,0x18,0x1C, one per cycle;
//      concurrent pushes after st_ready=1 follow in order; pointer wrap checked.
//   6. rst_n low with 3 entries pending -> mem_req=0 immediately, count=0, empty=1.

Source files
------------

// File: rtl/mem_store_buffer.sv
// Store buffer between the MEM stage and data memory.
// Aligns SB/SH/SW stores, queues up to DEPTH of them, and drains them over a req/ack write port.
module mem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    st_valid,
   output logic                    st_ready,
   input  logic [AW-1:0]           st_addr,
   input  logic [DW-1:0]           st_data,
   input  logic [1:0]              st_size,
   output logic                    mem_req,
   input  logic                    mem_ack,
   output logic [AW-1:0]           mem_addr,
   output logic [DW-1:0]           mem_wdata,
   output logic [3:0]              mem_be,
   output logic                    misalign,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_mem  [DEPTH];
   logic [DW-1:0] wdata_mem [DEPTH];
   logic [3:0]    be_mem    [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          accept;
   logic          legal;
   logic          push;
   logic          pop;
   logic [DW-1:0] al_data;
   logic [3:0]    al_be;

   assign empty    = (count == '0);
   assign st_ready = (count != CW'(DEPTH));
   assign mem_req  = !empty;
   assign accept   = st_valid && st_ready;
   assign push     = accept && legal;
   assign pop      = mem_req && mem_ack;

   // Outputs read zero while nothing is held, so reset leaves them at 0 without clearing storage.
   assign mem_addr  = mem_req ? addr_mem[rd_ptr]  : '0;
   assign mem_wdata = mem_req ? wdata_mem[rd_ptr] : '0;
   assign mem_be    = mem_req ? be_mem[rd_ptr]    : '0;

   always_comb begin
      legal   = 1'b0;
      al_data = st_data;
      al_be   = 4'b0000;
      case (st_size)
         2'b00: begin
            legal   = 1'b1;
            al_data = {4{st_data[7:0]}};
            al_be   = 4'b0001 << st_addr[1:0];
         end
         2'b01: begin
            legal   = !st_addr[0];
            al_data = {2{st_data[15:0]}};
            al_be   = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         2'b10: begin
            legal   = (st_addr[1:0] == 2'b00);
            al_data = st_data;
            al_be   = 4'b1111;
         end
         default: begin
            legal   = 1'b0;
            al_data = st_data;
            al_be   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr]  <= {st_addr[AW-1:2], 2'b00};
         wdata_mem[wr_ptr] <= al_data;
         be_mem[wr_ptr]    <= al_be;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         misalign <= 1'b0;
      end else begin
         misalign <= accept && !legal;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

endmodule
